// File: rtl/tcm_pkg.sv
// Shared encodings for the tightly-coupled memory controller.
package tcm_pkg;

  // Request access size.
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  // Controller state encoding.
  typedef logic [1:0] tcm_state_t;
  localparam tcm_state_t ST_IDLE = 2'd0;
  localparam tcm_state_t ST_RD   = 2'd1;
  localparam tcm_state_t ST_RSP  = 2'd2;

  // Byte-lane masks for lane 0; shifted by the byte offset at use.
  localparam logic [3:0] WEM_BYTE = 4'b0001;
  localparam logic [3:0] WEM_HALF = 4'b0011;
  localparam logic [3:0] WEM_WORD = 4'b1111;

  function automatic logic [3:0] base_mask(input logic [1:0] size);
    case (size)
      SZ_BYTE: return WEM_BYTE;
      SZ_HALF: return WEM_HALF;
      default: return WEM_WORD;
    endcase
  endfunction

endpackage

// File: rtl/tcm_ld_align.sv
// Load data alignment: picks the addressed lane(s) out of a RAM word and
// sign- or zero-extends to 32 bits. Purely combinational.
module tcm_ld_align
  import tcm_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] result
);

  logic [31:0] shifted;

  // Right-justify the addressed bytes, then extend to the full width.
  always_comb begin
    shifted = word >> {offset, 3'b000};
    case (size)
      SZ_BYTE: result = {{24{~is_unsigned & shifted[7]}},  shifted[7:0]};
      SZ_HALF: result = {{16{~is_unsigned & shifted[15]}}, shifted[15:0]};
      default: result = shifted;
    endcase
  end

endmodule

// File: rtl/tcm_ctrl.sv
// Single-outstanding request controller in front of a synchronous
// word-wide RAM with byte write enables.
// Optional macro TCM_CTRL_MISALIGN_CHK_EN: when defined, misaligned
// half/word accesses and the illegal size code return an error response
// instead of touching the RAM.
//
// state    | meaning
// ---------+-----------------------------------------------------
// ST_IDLE  | no request outstanding, ready for a new one
// ST_RD    | load accepted, RAM read data arrives this cycle
// ST_RSP   | response presented, waiting for rsp_ready
module tcm_ctrl
  import tcm_pkg::*;
#(
  parameter int DP     = 512,
  parameter int AW     = 32,
  parameter int RAM_AW = $clog2(DP)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [AW-1:0]     req_addr,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_din,
  output logic              ram_we,
  output logic [3:0]        ram_wem,
  input  logic [31:0]       ram_dout
);

  tcm_state_t        state_q;
  logic [RAM_AW-1:0] addr_q;
  logic [1:0]        off_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [31:0]       rdata_q;
  logic              err_q;

  logic              fire;
  logic              req_err;
  logic [1:0]        size_eff;
  logic [1:0]        off_eff;
  logic [31:0]       ld_result;

  // Upper address bits alias onto the RAM (wrap modulo depth).
  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr[AW-1:RAM_AW+2];

`ifdef TCM_CTRL_MISALIGN_CHK_EN
  assign req_err = (req_size == SZ_ILL)
                 || ((req_size == SZ_HALF) && req_addr[0])
                 || ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
`else
  assign req_err = 1'b0;
`endif

  assign req_ready = rst_n && ((state_q == ST_IDLE) || ((state_q == ST_RSP) && rsp_ready));
  assign fire      = req_valid && req_ready;

  assign rsp_valid = (state_q == ST_RSP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  // Normalise size/offset: illegal size acts as word, sub-lane bits that
  // cannot matter for the size are dropped.
  always_comb begin
    size_eff = (req_size == SZ_ILL) ? SZ_WORD : req_size;
    case (size_eff)
      SZ_BYTE: off_eff = req_addr[1:0];
      SZ_HALF: off_eff = {req_addr[1], 1'b0};
      default: off_eff = 2'b00;
    endcase
  end

  // RAM port: address is live on fire and held otherwise so the RAM's
  // registered read stays pointed at the accepted word.
  always_comb begin
    ram_addr = fire ? req_addr[RAM_AW+1:2] : addr_q;
    ram_we   = fire && req_we && !req_err;
    ram_wem  = base_mask(size_eff) << off_eff;
    case (size_eff)
      SZ_BYTE: ram_din = {4{req_wdata[7:0]}};
      SZ_HALF: ram_din = {2{req_wdata[15:0]}};
      default: ram_din = req_wdata;
    endcase
  end

  tcm_ld_align u_ld_align (
    .word        (ram_dout),
    .offset      (off_q),
    .size        (size_q),
    .is_unsigned (uns_q),
    .result      (ld_result)
  );

  // Request/response sequencing and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      off_q   <= 2'b00;
      size_q  <= SZ_BYTE;
      uns_q   <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_RSP: begin
          if (fire) begin
            addr_q <= req_addr[RAM_AW+1:2];
            if (req_err || req_we) begin
              state_q <= ST_RSP;
              rdata_q <= '0;
              err_q   <= req_err;
            end else begin
              state_q <= ST_RD;
              off_q   <= off_eff;
              size_q  <= size_eff;
              uns_q   <= req_unsigned;
            end
          end else if (state_q == ST_RSP && rsp_ready) begin
            state_q <= ST_IDLE;
          end
        end
        ST_RD: begin
          rdata_q <= ld_result;
          err_q   <= 1'b0;
          state_q <= ST_RSP;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tcm_ctrl.sv
// Bench for tcm_ctrl: directed scenarios plus randomized traffic, checked
// against a byte-array memory model and per-request response expectations.
module tb_tcm_ctrl;

  localparam int DP = 512;
  localparam int RAW = $clog2(DP);

  logic            clk = 1'b0;
  logic            rst_n;
  logic            req_valid;
  logic            req_ready;
  logic [31:0]     req_addr;
  logic            req_we;
  logic [1:0]      req_size;
  logic            req_unsigned;
  logic [31:0]     req_wdata;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [31:0]     rsp_rdata;
  logic            rsp_err;
  logic [RAW-1:0]  ram_addr;
  logic [31:0]     ram_din;
  logic            ram_we;
  logic [3:0]      ram_wem;
  logic [31:0]     ram_dout;

  tcm_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .ram_addr     (ram_addr),
    .ram_din      (ram_din),
    .ram_we       (ram_we),
    .ram_wem      (ram_wem),
    .ram_dout     (ram_dout)
  );

  always #5 clk = ~clk;

  // Synchronous RAM with byte enables and registered read.
  logic [31:0] ram_mem [DP];
  always @(posedge clk) begin
    if (ram_we)
      for (int j = 0; j < 4; j++)
        if (ram_wem[j]) ram_mem[ram_addr][8*j +: 8] <= ram_din[8*j +: 8];
    ram_dout <= ram_mem[ram_addr];
  end

  // Reference model state.
  byte unsigned mdl [DP*4];
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  bit          pend = 0;
  int          pend_cyc, pend_lat;
  logic [31:0] pend_rdata;
  bit          pend_err;
  int          last_waddr = 0;
  logic [31:0] last_rdata;
  logic        last_err;
  int          last_fire_cyc;
  bit          rand_rr = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock: called at a falling edge, samples just before the rising edge.
  task automatic tick(output bit fired);
    bit vis, exp_ready, err, exp_we;
    int unsigned ua;
    int n, off, base, widx;
    logic [31:0] din, val;
    logic [3:0] mask;
    longint v;
    if (rand_rr) rsp_ready = ($urandom_range(0, 3) != 0);
    #3;
    vis = pend && (cyc >= pend_cyc + pend_lat);
    exp_ready = !pend || (vis && rsp_ready);
    chk("rsp_valid", rsp_valid, vis);
    chk("req_ready", req_ready, exp_ready);
    if (vis) begin
      chk("rsp_rdata", rsp_rdata, pend_rdata);
      chk("rsp_err", rsp_err, pend_err);
      if (rsp_ready) begin
        last_rdata = rsp_rdata;
        last_err   = rsp_err;
        pend = 0;
      end
    end
    fired = req_valid && exp_ready;
    if (fired) begin
      ua = req_addr;
      err = 0;
`ifdef TCM_CTRL_MISALIGN_CHK_EN
      err = (req_size == 2'd3) || (req_size == 2'd1 && ua % 2 != 0)
         || (req_size == 2'd2 && ua % 4 != 0);
`endif
      n    = (req_size == 2'd0) ? 1 : (req_size == 2'd1) ? 2 : 4;
      off  = (n == 1) ? int'(ua % 4) : (n == 2) ? int'((ua % 4) / 2 * 2) : 0;
      widx = int'((ua / 4) % DP);
      base = widx * 4;
      exp_we = req_we && !err;
      chk("ram_addr_fire", 32'(ram_addr), widx);
      chk("ram_we_fire", ram_we, exp_we);
      if (exp_we) begin
        din = 0; mask = 0;
        for (int j = 0; j < 4; j++) din |= ((req_wdata >> (8 * (j % n))) & 32'hFF) << (8 * j);
        for (int i = 0; i < n; i++) begin
          mask |= 4'(1 << (off + i));
          mdl[base + off + i] = 8'((req_wdata >> (8 * i)) & 32'hFF);
        end
        chk("ram_wem", ram_wem, mask);
        chk("ram_din", ram_din, din);
      end
      pend = 1; pend_cyc = cyc; last_fire_cyc = cyc;
      if (err || req_we) begin
        pend_rdata = 0; pend_err = err; pend_lat = 1;
      end else begin
        v = 0;
        for (int i = 0; i < n; i++) v += longint'(mdl[base + off + i]) << (8 * i);
        if (!req_unsigned && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
        val = v[31:0];
        pend_rdata = val; pend_err = 0; pend_lat = 2;
      end
      last_waddr = widx;
    end else begin
      chk("ram_we_idle", ram_we, 1'b0);
      chk("ram_addr_hold", 32'(ram_addr), last_waddr);
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic issue(input bit we, input logic [1:0] sz, input bit uns,
                       input logic [31:0] addr, input logic [31:0] wd);
    bit f = 0;
    req_valid = 1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    for (int k = 0; k < 30 && !f; k++) tick(f);
    if (!f) chk("req_timeout", 32'(f), 32'd1);
    req_valid = 0;
  endtask

  task automatic idle(input int n);
    bit f;
    for (int k = 0; k < n; k++) tick(f);
  endtask

  task automatic drain();
    bit f;
    rsp_ready = 1;
    for (int k = 0; k < 20 && pend; k++) tick(f);
    if (pend) chk("drain_timeout", 32'(pend), 32'd0);
  endtask

  // Asynchronous reset pulse, entered and left at a falling edge.
  task automatic reset_pulse();
    rst_n = 0;
    #1;
    chk("rst_req_ready", req_ready, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", rsp_err, 1'b0);
    chk("rst_ram_we", ram_we, 1'b0);
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    #1;
    rst_n = 1;
    pend = 0;
    last_waddr = 0;
    @(negedge clk);
  endtask

  initial begin
    int c1, c2, c3;
    for (int i = 0; i < DP; i++) ram_mem[i] = 0;
    for (int i = 0; i < DP * 4; i++) mdl[i] = 0;
    ram_dout = 0;
    rst_n = 0; req_valid = 0; req_addr = 0; req_we = 0; req_size = 0;
    req_unsigned = 0; req_wdata = 0; rsp_ready = 1;
    @(negedge clk);
    reset_pulse();
    idle(2);

    // Word store/load round trip, then byte store and sign/zero-extended loads.
    issue(1, 2'd2, 0, 32'h8, 32'h12345678);
    issue(0, 2'd2, 0, 32'h8, 0);
    drain();
    chk("lw_08", last_rdata, 32'h12345678);
    chk("lw_08_err", last_err, 1'b0);
    issue(1, 2'd0, 0, 32'h9, 32'h000000AB);
    issue(0, 2'd2, 0, 32'h8, 0);
    drain();
    chk("lw_08_merge", last_rdata, 32'h1234AB78);
    issue(0, 2'd0, 0, 32'h9, 0);
    drain();
    chk("lb_09", last_rdata, 32'hFFFFFFAB);
    issue(0, 2'd0, 1, 32'h9, 0);
    drain();
    chk("lbu_09", last_rdata, 32'h000000AB);
    issue(1, 2'd2, 0, 32'h8, 32'h80011234);
    issue(0, 2'd1, 0, 32'hA, 0);
    drain();
    chk("lh_0a", last_rdata, 32'hFFFF8001);
    issue(0, 2'd1, 1, 32'hA, 0);
    drain();
    chk("lhu_0a", last_rdata, 32'h00008001);

    // Stalled response, then back-to-back stores.
    rsp_ready = 0;
    issue(0, 2'd2, 0, 32'h8, 0);
    idle(6);
    rsp_ready = 1;
    issue(1, 2'd2, 0, 32'h10, 32'hA5A5A5A5); c1 = last_fire_cyc;
    issue(1, 2'd1, 0, 32'h14, 32'h0000BEEF); c2 = last_fire_cyc;
    issue(1, 2'd0, 0, 32'h17, 32'h00000042); c3 = last_fire_cyc;
    drain();
    chk("b2b_gap1", c2 - c1, 1);
    chk("b2b_gap2", c3 - c2, 1);

    // Misaligned word store.
    issue(1, 2'd2, 0, 32'h6, 32'hCAFEF00D);
    drain();
`ifdef TCM_CTRL_MISALIGN_CHK_EN
    chk("sw_06_err", last_err, 1'b1);
`else
    chk("sw_06_err", last_err, 1'b0);
    issue(0, 2'd2, 0, 32'h4, 0);
    drain();
    chk("lw_04", last_rdata, 32'hCAFEF00D);
`endif

    // Reset while the load is in RD drops its response.
    issue(0, 2'd2, 0, 32'h10, 0);
    reset_pulse();
    idle(4);
    issue(0, 2'd2, 0, 32'h10, 0);
    drain();
    chk("lw_after_rst", last_rdata, 32'hA5A5A5A5);

    // Randomized traffic, addresses aliased through the upper bits.
    rand_rr = 1;
    for (int t = 0; t < 400; t++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 3) == 0) ? $urandom : (($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63)));
      issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), a, $urandom);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    rand_rr = 0;
    drain();
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tcm_ctrl.md
TCM_CTRL -- requirements
Module: tcm_ctrl

Interface
REQ-001 SHALL have parameter DP, 512, RAM depth in 32-bit words.
REQ-002 SHALL have parameter AW, 32, request byte-address width.
REQ-003 SHALL have parameter RAM_AW, $clog2(DP), RAM word-address width.
REQ-004 SHALL have ports: clk  in  1  clock, all state on rising edge; rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid  in  1  request valid; req_ready  out  1  request accepted when both high (fire).
REQ-006 SHALL have port req_addr  in  AW  byte address; req_we  in  1  1=store, 0=load.
REQ-007 SHALL have port req_size  in  2  00 byte, 01 half, 10 word, 11 illegal; req_unsigned  in  1  zero-extend load.
REQ-008 SHALL have port req_wdata  in  32  store data, right-aligned.
REQ-009 SHALL have port rsp_valid  out  1; rsp_ready  in  1; rsp_rdata  out  32  load result; rsp_err  out  1  access error.
REQ-010 SHALL have port ram_addr  out  RAM_AW; ram_din  out  32; ram_we  out  1; ram_wem  out  4  byte mask; ram_dout  in  32.

Function
REQ-011 SHALL use states IDLE, RD, RSP; one request outstanding.
REQ-012 SHALL set req_ready = (IDLE) or (RSP and rsp_ready); 0 in RD and while rst_n low.
REQ-013 SHALL drive ram_addr = req_addr[RAM_AW+1:2] combinationally on fire, else the last fired word address (held register), so RAM read-address register stays stable.
REQ-014 SHALL assert ram_we only in a fire cycle with req_we=1 and no error; ram_wem: byte 0001<<a[1:0], half 0011<<{a[1],0}, word 1111; ram_din: byte {4{b}}, half {2{h}}, word as-is.
REQ-015 Store: fire -> RSP next cycle, rsp_valid=1, rsp_rdata=0, rsp_err=0 (latency 1).
REQ-016 Load: fire -> RD; in RD capture ram_dout, shift by byte offset, sign- or zero-extend per req_size/req_unsigned into rsp_rdata -> RSP (latency 2).
REQ-017 SHALL hold rsp_valid, rsp_rdata, rsp_err stable in RSP until rsp_ready; rsp_ready without new fire -> IDLE, rsp_valid=0.
REQ-018 RSP with rsp_ready and simultaneous fire SHALL retire the old response and start the new request same cycle (back-to-back stores, one per cycle).
REQ-019 Word-address bits above RAM_AW+1 SHALL be ignored (wrap modulo DP).

Reset
REQ-020 rst_n low SHALL asynchronously force IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0, held address=0, ram_we=0.
REQ-021 Reset during RD or RSP SHALL drop the in-flight response; no response issued after release.

Configuration
REQ-022 Macro TCM_CTRL_MISALIGN_CHK_EN defined: half with a[0]=1, word with a[1:0]!=0, or size 11 SHALL flag error: no RAM write, rsp_rdata=0, rsp_err=1, latency 1.
REQ-023 Macro undefined: rsp_err tied 0; half ignores a[0]; word ignores a[1:0]; size 11 treated as word.

Structure
REQ-024 Package tcm_pkg SHALL hold size encodings, state enum, byte-mask constants.
REQ-025 Load extract/extend SHALL be sub-module tcm_ld_align (combinational: word, offset, size, unsigned -> 32-bit result).

Verification
REQ-026 Store word 0x12345678 @0x8, then load word @0x8 -> rsp_rdata=0x12345678 two cycles after load fire, rsp_err=0.
REQ-027 Store byte 0xAB @0x9 over 0x12345678 -> ram_wem=0010; load word -> 0x1234AB78; lb @0x9 -> 0xFFFFFFAB; lbu -> 0x000000AB.
REQ-028 lh @0xA of 0x8001xxxx -> 0xFFFF8001; lhu -> 0x00008001.
REQ-029 rsp_ready held low 5 cycles after load -> rsp_valid/rsp_rdata stable, req_ready=0; then 3 stores with rsp_ready=1 -> one response per cycle.
REQ-030 With TCM_CTRL_MISALIGN_CHK_EN: sw @0x6 -> ram_we never asserted, rsp_err=1 after 1 cycle; without: writes word 1 with mask 1111.
REQ-031 rst_n pulsed low in RD -> rsp_valid stays 0, next request served normally.
